// File: rtl/amm_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : amm_wr_arb_pkg
// Purpose : Shared types and helpers for the amm_wr_arb write arbiter.
//           - arb_state_t : shared-port state (IDLE / ISSUE)
//           - clog2_min1  : index width that never collapses to zero bits
// Revision: 1.0 - initial release
// ============================================================================
package amm_wr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  // Width of an index into n requesters; at least one bit so that a
  // single-bit grant register still exists for the smallest configurations.
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/amm_wr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : amm_wr_arb_rr_pick
// Purpose : Combinational requester picker for amm_wr_arb.
//           Default: round robin, searching last_grant+1, +2, ... mod NUM_REQ.
//           AMM_WR_ARB_FIXED_PRIO_EN defined: lowest set index wins and the
//           last_grant input is removed.
// Ports   : req        in  [NUM_REQ-1:0]  request vector
//           last_grant in  [IDX_W-1:0]    previous winner (round robin only)
//           valid      out 1              any request present
//           idx        out [IDX_W-1:0]    winning index
// Revision: 1.0 - initial release
// ============================================================================
module amm_wr_arb_rr_pick
  import amm_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef AMM_WR_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   last_grant,
`endif
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  assign valid = |req;

`ifdef AMM_WR_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] w_cand;

  // Scan offsets from farthest to nearest so that the nearest requester
  // after last_grant is the final (winning) assignment.
  always_comb begin
    idx    = '0;
    w_cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (req[w_cand]) idx = w_cand;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/amm_wr_arb.sv
`default_nettype none
// ============================================================================
// Module  : amm_wr_arb
// Purpose : Shares one Avalon-MM write master port among NUM_REQ Avalon-MM
//           write requesters. The winning request is registered onto the
//           shared port; m_waitrequest stalls hold the shared port unchanged.
// Config  : AMM_WR_ARB_FIXED_PRIO_EN - fixed priority (lowest index wins),
//           otherwise round robin starting at requester 0 after reset.
// Ports   : clk, rst_n (async active-low)
//           s_address/s_write/s_writedata/s_byteenable  per-requester inputs
//           s_waitrequest  per-requester stall, low only in the accept cycle
//           m_address/m_write/m_writedata/m_byteenable  registered master
//           m_waitrequest  downstream stall
// Revision: 1.0 - initial release
// ============================================================================
module amm_wr_arb
  import amm_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int BYTE_CNT   = DATA_WIDTH / 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  s_address,
  input  logic [NUM_REQ-1:0]                  s_write,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  s_writedata,
  input  logic [NUM_REQ-1:0][BYTE_CNT-1:0]    s_byteenable,
  output logic [NUM_REQ-1:0]                  s_waitrequest,
  output logic [ADDR_WIDTH-1:0]               m_address,
  output logic                                m_write,
  output logic [DATA_WIDTH-1:0]               m_writedata,
  output logic [BYTE_CNT-1:0]                 m_byteenable,
  input  logic                                m_waitrequest
);

  localparam int IDX_W = clog2_min1(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("amm_wr_arb: NUM_REQ must be in 2..8");
  end

  arb_state_t              r_state;
  logic [ADDR_WIDTH-1:0]   r_address;
  logic [DATA_WIDTH-1:0]   r_writedata;
  logic [BYTE_CNT-1:0]     r_byteenable;

  logic                    w_slot_free;
  logic                    w_accept;
  logic                    w_pick_valid;
  logic [IDX_W-1:0]        w_pick_idx;

`ifndef AMM_WR_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]        r_last_grant;
`endif

  amm_wr_arb_rr_pick #(
    .NUM_REQ    (NUM_REQ),
    .IDX_W      (IDX_W)
  ) u_rr_pick (
    .req        (s_write),
`ifndef AMM_WR_ARB_FIXED_PRIO_EN
    .last_grant (r_last_grant),
`endif
    .valid      (w_pick_valid),
    .idx        (w_pick_idx)
  );

  // The slot is free when idle or when the in-flight write completes this
  // cycle, which allows a new accept in the completion cycle (no bubble).
  assign w_slot_free = (r_state == IDLE) | ~m_waitrequest;

  // Gating with rst_n keeps every s_waitrequest high while reset is held,
  // even though the state already reads IDLE.
  assign w_accept = rst_n & w_slot_free & w_pick_valid;

  always_comb begin
    s_waitrequest = '1;
    if (w_accept) s_waitrequest[w_pick_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_address    <= '0;
      r_writedata  <= '0;
      r_byteenable <= '0;
`ifndef AMM_WR_ARB_FIXED_PRIO_EN
      r_last_grant <= IDX_W'(NUM_REQ - 1);
`endif
    end else if (w_accept) begin
      r_state      <= ISSUE;
      r_address    <= s_address[w_pick_idx];
      r_writedata  <= s_writedata[w_pick_idx];
      r_byteenable <= s_byteenable[w_pick_idx];
`ifndef AMM_WR_ARB_FIXED_PRIO_EN
      r_last_grant <= w_pick_idx;
`endif
    end else if (w_slot_free) begin
      // Completed (or idle) with nothing pending: data registers keep
      // their last values, only the write strobe drops.
      r_state      <= IDLE;
    end
  end

  assign m_write      = (r_state == ISSUE);
  assign m_address    = r_address;
  assign m_writedata  = r_writedata;
  assign m_byteenable = r_byteenable;

endmodule
`default_nettype wire

// File: tb/tb_amm_wr_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_amm_wr_arb
// Purpose : Self-checking bench for amm_wr_arb. A driver applies directed and
//           random stimulus, predicts the grant from the arbitration rules
//           and queues the expected shared-port transfer; an independent
//           monitor pops and compares each completed transfer and checks
//           the hold rule during stalls.
// Revision: 1.0 - initial release
// ============================================================================
module tb_amm_wr_arb;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0][AW-1:0] s_address;
  logic [N-1:0]         s_write;
  logic [N-1:0][DW-1:0] s_writedata;
  logic [N-1:0][BW-1:0] s_byteenable;
  logic [N-1:0]         s_waitrequest;
  logic [AW-1:0]        m_address;
  logic                 m_write;
  logic [DW-1:0]        m_writedata;
  logic [BW-1:0]        m_byteenable;
  logic                 m_waitrequest;

  always #5 clk = ~clk;

  amm_wr_arb #(
    .NUM_REQ       (N),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .BYTE_CNT      (BW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_address     (s_address),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .s_byteenable  (s_byteenable),
    .s_waitrequest (s_waitrequest),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_waitrequest (m_waitrequest)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] b;
  } xact_t;

  xact_t exp_q[$];
  int    ncmp  = 0;
  int    nfail = 0;

  // Reference model state: is a transfer outstanding, and who won last.
  bit    busy = 1'b0;
  int    lg   = N - 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Winner per the arbitration rule; -1 when nobody requests.
  function automatic int pick(input logic [N-1:0] req);
`ifdef AMM_WR_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (req[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (req[(lg + k) % N]) return (lg + k) % N;
`endif
    return -1;
  endfunction

  // One clock cycle with the inputs already driven: predict and check the
  // accept decision at negedge, then advance the model on the posedge.
  task automatic step(output bit acc, output int g);
    logic [N-1:0] expw;
    bit           slot;
    xact_t        x;
    @(negedge clk);
    slot = !busy || !m_waitrequest;
    g    = pick(s_write);
    acc  = slot && (g >= 0);
    expw = '1;
    if (acc) expw[g] = 1'b0;
    check("s_waitrequest", 64'(s_waitrequest), 64'(expw));
    check("m_write", 64'(m_write), 64'(busy));
    if (acc) begin
      x.a = s_address[g];
      x.d = s_writedata[g];
      x.b = s_byteenable[g];
      exp_q.push_back(x);
    end
    @(posedge clk);
    if (acc) begin
      busy = 1'b1;
      lg   = g;
    end else if (slot) begin
      busy = 1'b0;
    end
    #1;
  endtask

  task automatic rand_payload(input int i);
    s_address[i]    = AW'($urandom);
    s_writedata[i]  = $urandom;
    s_byteenable[i] = BW'($urandom);
  endtask

  // Monitor: compares every completed shared-port transfer against the
  // queue and checks that a stalled transfer is held unchanged.
  initial begin
    xact_t prev;
    xact_t e;
    bit    prev_stall;
    prev_stall = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("hold_during_stall", 64'({m_address, m_writedata, m_byteenable}), 64'(prev));
        if (m_write && !m_waitrequest) begin
          if (exp_q.size() == 0) begin
            ncmp++;
            nfail++;
            $display("FAIL unexpected_transfer: actual addr=%0h data=%0h required none at %0t",
                     m_address, m_writedata, $time);
          end else begin
            e = exp_q.pop_front();
            check("m_xact", 64'({m_address, m_writedata, m_byteenable}), 64'(e));
          end
        end
        prev_stall = m_write && m_waitrequest;
        prev       = {m_address, m_writedata, m_byteenable};
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int g;
    bit hold [N];

    s_address     = '0;
    s_write       = '0;
    s_writedata   = '0;
    s_byteenable  = '0;
    m_waitrequest = 1'b0;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_m_write", 64'(m_write), 64'(0));
    check("reset_m_address", 64'(m_address), 64'(0));
    check("reset_m_writedata", 64'(m_writedata), 64'(0));
    check("reset_m_byteenable", 64'(m_byteenable), 64'(0));
    check("reset_s_waitrequest", 64'(s_waitrequest), 64'({N{1'b1}}));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request from requester 1
    s_address[1]    = 16'h0010;
    s_writedata[1]  = 32'hDEADBEEF;
    s_byteenable[1] = 4'hF;
    s_write         = 2'b10;
    step(acc, g);
    s_write = '0;
    step(acc, g);
    step(acc, g);

    // Contention: both requesting continuously
    s_write = 2'b11;
    repeat (6) begin
      rand_payload(0);
      rand_payload(1);
      step(acc, g);
    end
    s_write = '0;
    repeat (2) step(acc, g);

    // Stall for 3 cycles, then back-to-back accept in the completion cycle
    s_address[0]    = 16'h0ABC;
    s_writedata[0]  = 32'h12345678;
    s_byteenable[0] = 4'h5;
    s_write         = 2'b01;
    step(acc, g);
    s_write       = 2'b10;
    rand_payload(1);
    m_waitrequest = 1'b1;
    repeat (3) step(acc, g);
    m_waitrequest = 1'b0;
    step(acc, g);
    s_write = '0;
    repeat (2) step(acc, g);

    // Random traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!hold[i] && ($urandom_range(1, 0) == 1)) begin
          hold[i] = 1'b1;
          rand_payload(i);
        end else if (hold[i] && ($urandom_range(15, 0) == 0)) begin
          hold[i] = 1'b0;
        end
        s_write[i] = hold[i];
      end
      m_waitrequest = ($urandom_range(9, 0) < 3);
      step(acc, g);
      if (acc) hold[g] = 1'b0;
    end
    s_write       = '0;
    m_waitrequest = 1'b0;
    repeat (2) step(acc, g);

    // Reset while a stalled transfer is in flight
    s_write = 2'b10;
    rand_payload(1);
    step(acc, g);
    m_waitrequest = 1'b1;
    s_write       = 2'b11;
    step(acc, g);
    rst_n = 1'b0;
    #1;
    check("rst_mid_m_write", 64'(m_write), 64'(0));
    check("rst_mid_s_waitrequest", 64'(s_waitrequest), 64'({N{1'b1}}));
    busy = 1'b0;
    lg   = N - 1;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_waitrequest = 1'b0;
    rand_payload(0);
    rand_payload(1);
    step(acc, g);
    repeat (3) step(acc, g);
    s_write = '0;
    repeat (3) step(acc, g);

    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
